// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types for the 8-bit accumulator CPU.
//   opcode_e  : IR opcode encoding (also used by alu_m)
//   state_e   : controller sequencing states; HALTED sits outside the 8 phases
//   strobes_t : datapath strobe bundle produced by the decoder
package cpu_pkg;

  localparam int NUM_PHASES = 8;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_e;

  // The low 3 bits of the 8 phase states are the visible phase number.
  // HALTED uses a fourth bit so it never aliases STORE internally.
  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_e;

  typedef struct packed {
    logic mem_rd;
    logic mem_wr;
    logic load_ir;
    logic load_ac;
    logic inc_pc;
    logic load_pc;
    logic halt;
  } strobes_t;

  // Opcodes that read an operand from memory and load the accumulator.
  function automatic logic is_aluop(opcode_e op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/ctrl_decode_m.sv
// ctrl_decode_m: pure combinational decode of controller state, opcode and
// the ALU zero flag into the datapath strobes.
//   state_i  : current controller state
//   opcode_i : IR opcode (only consulted from OP_ADDR onward)
//   zero_i   : accumulator-is-zero flag (only consulted in ALU_OP)
//   strb_o   : decoded strobes
module ctrl_decode_m
  import cpu_pkg::*;
(
  input  state_e   state_i,
  input  opcode_e  opcode_i,
  input  logic     zero_i,
  output strobes_t strb_o
);

  always_comb begin
    strb_o = '0;
    // The fetch phases never look at opcode, so a stale or X opcode there
    // cannot disturb the strobes.
    case (state_i)
      INST_FETCH: strb_o.mem_rd = 1'b1;
      INST_LOAD, IDLE: begin
        strb_o.mem_rd  = 1'b1;
        strb_o.load_ir = 1'b1;
      end
      OP_ADDR: begin
        strb_o.inc_pc = 1'b1;
        strb_o.halt   = (opcode_i == HLT);
      end
      OP_FETCH: strb_o.mem_rd = is_aluop(opcode_i);
      ALU_OP: begin
        strb_o.mem_rd  = is_aluop(opcode_i);
        strb_o.load_ac = is_aluop(opcode_i);
        strb_o.inc_pc  = (opcode_i == SKZ) && zero_i;
        strb_o.load_pc = (opcode_i == JMP);
      end
      STORE: begin
        strb_o.mem_rd  = is_aluop(opcode_i);
        strb_o.load_ac = is_aluop(opcode_i);
        strb_o.inc_pc  = (opcode_i == JMP);
        strb_o.load_pc = (opcode_i == JMP);
        strb_o.mem_wr  = (opcode_i == STO);
      end
      HALTED: strb_o.halt = 1'b1;
      default: strb_o = '0;  // INST_ADDR and unreachable encodings
    endcase
  end

endmodule

// File: rtl/control_m.sv
// control_m: sequence controller for the 8-bit accumulator CPU.
// Walks each instruction through 8 phases, enters HALTED on HLT and counts
// retired instructions.
//   clk, rst     : clock, asynchronous active-high reset
//   opcode, zero : IR opcode and ALU zero flag
//   mem_rd .. halt : datapath strobes (combinational from state/opcode)
//   phase        : current phase, 3'b111 while halted
//   instr_count  : retired-instruction counter, wraps
module control_m
  import cpu_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  opcode_e              opcode,
  input  logic                 zero,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic                 load_ir,
  output logic                 load_ac,
  output logic                 inc_pc,
  output logic                 load_pc,
  output logic                 halt,
  output logic [2:0]           phase,
  output logic [CNT_WIDTH-1:0] instr_count
);

  state_e               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  strobes_t             dec;
  strobes_t             strb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INST_ADDR;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        INST_ADDR:  state_q <= INST_FETCH;
        INST_FETCH: state_q <= INST_LOAD;
        INST_LOAD:  state_q <= IDLE;
        IDLE:       state_q <= OP_ADDR;
        OP_ADDR:    state_q <= (opcode == HLT) ? HALTED : OP_FETCH;
        OP_FETCH:   state_q <= ALU_OP;
        ALU_OP:     state_q <= STORE;
        STORE: begin
          state_q <= INST_ADDR;
          cnt_q   <= cnt_q + 1'b1;  // retire on wrap
        end
        HALTED:     state_q <= HALTED;  // only rst leaves
        default:    state_q <= INST_ADDR;
      endcase
    end
  end

  ctrl_decode_m u_dec (
    .state_i  (state_q),
    .opcode_i (opcode),
    .zero_i   (zero),
    .strb_o   (dec)
  );

  // Strobes are forced low for the whole time rst is high, including the
  // part of a cycle before the state register has been cleared.
  assign strb = rst ? '0 : dec;

  assign mem_rd      = strb.mem_rd;
  assign mem_wr      = strb.mem_wr;
  assign load_ir     = strb.load_ir;
  assign load_ac     = strb.load_ac;
  assign inc_pc      = strb.inc_pc;
  assign load_pc     = strb.load_pc;
  assign halt        = strb.halt;
  assign phase       = (state_q == HALTED) ? 3'b111 : state_q[2:0];
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_control_m.sv
module tb_control_m;
  import cpu_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  opcode_e       opcode;
  logic          zero;
  logic          mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt;
  logic [2:0]    phase;
  logic [CW-1:0] instr_count;

  control_m #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .load_ir(load_ir), .load_ac(load_ac),
    .inc_pc(inc_pc), .load_pc(load_pc), .halt(halt),
    .phase(phase), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: phase number, halted flag, retired count.
  int m_phase = 0;
  bit m_halt  = 1'b0;
  int m_cnt   = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_halt <= 1'b0; m_cnt <= 0;
    end else if (!m_halt) begin
      if (m_phase == 4 && opcode == HLT) m_halt <= 1'b1;
      else if (m_phase == NUM_PHASES - 1) begin
        m_phase <= 0;
        m_cnt   <= (m_cnt + 1) % (1 << CW);
      end else m_phase <= m_phase + 1;
    end
  end

  // Expected {mem_rd,mem_wr,load_ir,load_ac,inc_pc,load_pc,halt,phase,count}.
  function automatic logic [13:0] model_out();
    logic alu, rd, wr, ir, ac, inc, ld, h;
    logic [2:0] ph;
    alu = opcode inside {ADD, AND, XOR, LDA};
    ph  = 3'(m_phase);
    rd = 0; wr = 0; ir = 0; ac = 0; inc = 0; ld = 0; h = 0;
    if (rst) ph = 3'd0;
    else if (m_halt) begin h = 1; ph = 3'd7; end
    else begin
      rd  = (m_phase inside {1, 2, 3}) || (m_phase >= 5 && alu);
      ir  = m_phase inside {2, 3};
      ac  = m_phase >= 6 && alu;
      inc = (m_phase == 4) || (m_phase == 6 && opcode == SKZ && zero) ||
            (m_phase == 7 && opcode == JMP);
      ld  = m_phase >= 6 && opcode == JMP;
      wr  = m_phase == 7 && opcode == STO;
      h   = m_phase == 4 && opcode == HLT;
    end
    return {rd, wr, ir, ac, inc, ld, h, ph, CW'(rst ? 0 : m_cnt)};
  endfunction

  always @(negedge clk)
    chk("cycle", 32'({mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt,
                      phase, instr_count}), 32'(model_out()));

  // Per-phase strobe recordings of the last instruction (bit p = phase p).
  logic [7:0] r_rd, r_wr, r_ir, r_ac, r_inc, r_ld, r_hlt;

  // Called just after the posedge that enters INST_ADDR. Opcode is junk
  // until IDLE; zm 0/1 forces zero in ALU_OP, 2 leaves it random.
  task automatic run_instr(input opcode_e op, input int zm);
    for (int p = 0; p < 8; p++) begin
      opcode = (p >= 3) ? op : opcode_e'($urandom_range(0, 7));
      zero   = (p == 6 && zm < 2) ? zm[0] : 1'($urandom_range(0, 1));
      @(negedge clk);
      r_rd[p] = mem_rd; r_wr[p] = mem_wr; r_ir[p] = load_ir; r_ac[p] = load_ac;
      r_inc[p] = inc_pc; r_ld[p] = load_pc; r_hlt[p] = halt;
      @(posedge clk); #2;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  initial begin
    logic [CW-1:0] saved;
    opcode_e op;
    rst = 1'b1; opcode = ADD; zero = 1'b0;
    #1;
    chk("rst_phase", 32'(phase), 0);
    chk("rst_cnt", 32'(instr_count), 0);
    chk("rst_strb", 32'({mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt}), 0);
    @(posedge clk); #2; rst = 1'b0;

    run_instr(ADD, 2);
    chk("add_rd", 32'(r_rd), 32'h0EE);
    chk("add_ac", 32'(r_ac), 32'h0C0);
    chk("add_inc", 32'(r_inc), 32'h010);
    chk("add_ir", 32'(r_ir), 32'h00C);
    chk("add_cnt", 32'(instr_count), 1);

    run_instr(SKZ, 1);
    chk("skz1_inc", 32'(r_inc), 32'h050);
    run_instr(SKZ, 0);
    chk("skz0_inc", 32'(r_inc), 32'h010);
    run_instr(JMP, 2);
    chk("jmp_ld", 32'(r_ld), 32'h0C0);
    chk("jmp_inc", 32'(r_inc), 32'h090);
    chk("jmp_rd", 32'(r_rd), 32'h00E);
    run_instr(STO, 2);
    chk("sto_wr", 32'(r_wr), 32'h080);
    chk("cnt5", 32'(instr_count), 5);

    run_instr(HLT, 2);
    chk("hlt_halt", 32'(r_hlt), 32'h0F0);
    chk("hlt_rd", 32'(r_rd), 32'h00E);
    chk("hlt_phase", 32'(phase), 7);
    saved = instr_count;
    repeat (20) begin
      opcode = opcode_e'($urandom_range(0, 7)); zero = 1'($urandom_range(0, 1));
      @(posedge clk); #2;
    end
    chk("hlt_frozen", 32'(instr_count), 32'(saved));
    rst = 1'b1; #1;
    chk("hlt_rst_halt", 32'(halt), 0);
    chk("hlt_rst_cnt", 32'(instr_count), 0);
    @(posedge clk); #2; rst = 1'b0;

    // Async reset in the middle of ALU_OP.
    run_instr(ADD, 2);
    opcode = ADD;
    repeat (6) @(posedge clk);
    #3;
    chk("pre_ac", 32'(load_ac), 1);
    rst = 1'b1; #1;
    chk("async_strb", 32'({mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt}), 0);
    chk("async_phase", 32'(phase), 0);
    chk("async_cnt", 32'(instr_count), 0);
    @(posedge clk); #2; rst = 1'b0;
    run_instr(ADD, 2);
    chk("resume_rd", 32'(r_rd), 32'h0EE);
    chk("resume_cnt", 32'(instr_count), 1);

    // Counter wrap at CW=4.
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      run_instr(opcode_e'($urandom_range(1, 7)), 2);
      if (k == 15) chk("wrap15", 32'(instr_count), 15);
      if (k == 16) chk("wrap16", 32'(instr_count), 0);
      if (k == 17) chk("wrap17", 32'(instr_count), 1);
    end

    // Random instruction stream, model-checked every cycle.
    for (int i = 0; i < 250; i++) begin
      op = ($urandom_range(0, 9) == 0) ? HLT : opcode_e'($urandom_range(1, 7));
      run_instr(op, 2);
      if (op == HLT) begin
        repeat (20) begin
          opcode = opcode_e'($urandom_range(0, 7)); zero = 1'($urandom_range(0, 1));
          @(posedge clk); #2;
        end
        do_reset();
      end
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
